poly_mult_ctrl: RTL

Sequencer that runs one negacyclic polynomial multiplication through a shared `ntt_block_radix2_pipelined` engine. It accepts two pre-twisted polynomials and issues NTT(A) and NTT(B) back-to-back. It forms the pointwise product mod Q, issues iNTT of the product and returns the raw iNTT vector. Twisting, N⁻¹ scaling and untwisting are done outside this block. It sits between the host-side job interface and the NTT engine, and is the only driver of the engine's input ports.

---
 rtl/poly_mult_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/poly_mult_ctrl.sv
// poly_mult_ctrl: sequences NTT(A), NTT(B), pointwise mod-Q product
// and iNTT(C) through one shared NTT engine; returns the raw iNTT vector.
// Ports:
//   clk, reset (async, active-low)
//   start/in_ready/busy: job handshake
//   poly_a, poly_b: twisted inputs
//   done, result: completion pulse and held result
//   error, err_code, clear_err: 01 timeout, 10 mode mismatch
//   ntt_*: engine issue (valid_in/mode/data_in) and return
//          (valid_out/mode_out/data_out)
module poly_mult_ctrl #(
  parameter int              W         = 100,
  parameter int              N         = 8,
  parameter logic [W-1:0]    Modulus_Q = W'(64'd2147483777),
  parameter int              TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  in_ready,
  input  logic [N-1:0][W-1:0]   poly_a,
  input  logic [N-1:0][W-1:0]   poly_b,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0][W-1:0]   result,
  output logic                  error,
  output logic [1:0]            err_code,
  input  logic                  clear_err,
  output logic                  ntt_valid_in,
  output logic                  ntt_mode,
  output logic [N-1:0][W-1:0]   ntt_data_in,
  input  logic [N-1:0][W-1:0]   ntt_data_out,
  input  logic                  ntt_valid_out,
  input  logic                  ntt_mode_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE_A,
    S_ISSUE_B,
    S_WAIT_FWD,
    S_MULT,
    S_ISSUE_C,
    S_WAIT_INV,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  logic [N-1:0][W-1:0]  r_b;
  logic [N-1:0][W-1:0]  r_ahat;
  logic [N-1:0][W-1:0]  r_bhat;
  logic [1:0]           r_fwd_cnt;
  logic [7:0]           r_tmo;
  logic [N-1:0][W-1:0]  w_c;

  function automatic logic [W-1:0] mulmod(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [2*W-1:0] p;
    logic [2*W-1:0] q;
    q = {{W{1'b0}}, Modulus_Q};
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % q;
    return p[W-1:0];
  endfunction

  always_comb begin
    w_c = '0;
    for (int i = 0; i < N; i++) begin
      w_c[i] = mulmod(r_ahat[i], r_bhat[i]);
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_b          <= '0;
      r_ahat       <= '0;
      r_bhat       <= '0;
      r_fwd_cnt    <= '0;
      r_tmo        <= '0;
      done         <= 1'b0;
      result       <= '0;
      error        <= 1'b0;
      err_code     <= 2'b00;
      ntt_valid_in <= 1'b0;
      ntt_mode     <= 1'b0;
      ntt_data_in  <= '0;
    end else begin
      done         <= 1'b0;
      ntt_valid_in <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b          <= poly_b;
            r_fwd_cnt    <= '0;
            ntt_valid_in <= 1'b1;
            ntt_mode     <= 1'b0;
            ntt_data_in  <= poly_a;
            r_state      <= S_ISSUE_A;
          end
        end
        S_ISSUE_A: begin
          ntt_valid_in <= 1'b1;
          ntt_mode     <= 1'b0;
          ntt_data_in  <= r_b;
          r_state      <= S_ISSUE_B;
        end
        S_ISSUE_B: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_FWD;
          // With a one-cycle engine, A's transform is already back here.
          if (ntt_valid_out) begin
            if (ntt_mode_out) begin
              error    <= 1'b1;
              err_code <= 2'b10;
              r_state  <= S_ERR;
            end else begin
              r_ahat    <= ntt_data_out;
              r_fwd_cnt <= 2'd1;
            end
          end
        end
        S_WAIT_FWD: begin
          r_tmo <= r_tmo + 8'd1;
          if (ntt_valid_out) begin
            if (ntt_mode_out) begin
              error    <= 1'b1;
              err_code <= 2'b10;
              r_state  <= S_ERR;
            end else if (r_fwd_cnt == 2'd0) begin
              r_ahat    <= ntt_data_out;
              r_fwd_cnt <= 2'd1;
            end else begin
              r_bhat    <= ntt_data_out;
              r_fwd_cnt <= 2'd2;
              r_state   <= S_MULT;
            end
          end else if (r_tmo == TMO_LAST) begin
            error    <= 1'b1;
            err_code <= 2'b01;
            r_state  <= S_ERR;
          end
        end
        S_MULT: begin
          // The issue register doubles as the C register.
          ntt_valid_in <= 1'b1;
          ntt_mode     <= 1'b1;
          ntt_data_in  <= w_c;
          r_state      <= S_ISSUE_C;
        end
        S_ISSUE_C: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_INV;
        end
        S_WAIT_INV: begin
          r_tmo <= r_tmo + 8'd1;
          if (ntt_valid_out) begin
            if (!ntt_mode_out) begin
              error    <= 1'b1;
              err_code <= 2'b10;
              r_state  <= S_ERR;
            end else begin
              result  <= ntt_data_out;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (r_tmo == TMO_LAST) begin
            error    <= 1'b1;
            err_code <= 2'b01;
            r_state  <= S_ERR;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ERR: begin
          if (clear_err) begin
            error    <= 1'b0;
            err_code <= 2'b00;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
